// File: rtl/spi_led_bank_pkg.sv
// spi_led_bank_pkg
//   Shared definitions for the SPI LED bank: command framing constants,
//   local-op encodings, SPI FSM states and the local-op priority encoder.
//   No ports; imported by the channel and top modules.
package spi_led_bank_pkg;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_ADDR_W = 7;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    OP_INC = 2'd0,
    OP_DEC = 2'd1,
    OP_SHL = 2'd2,
    OP_SHR = 2'd3
  } op_code_e;

  typedef struct packed {
    logic     valid;
    op_code_e code;
  } op_t;

  localparam op_t OP_NONE = '{valid: 1'b0, code: OP_INC};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

  // When several button events hit a channel in the same cycle only the
  // highest-priority one survives: inc > dec > left > right.
  function automatic op_t encodeOp(input logic inc, input logic dec,
                                   input logic shl, input logic shr);
    op_t op;
    op.valid = inc | dec | shl | shr;
    if (inc)      op.code = OP_INC;
    else if (dec) op.code = OP_DEC;
    else if (shl) op.code = OP_SHL;
    else          op.code = OP_SHR;
    return op;
  endfunction

endpackage

// File: rtl/spi_led_bank_if.sv
// spi_led_bank_if
//   Bundles the SPI pins, the per-channel button events and the LED/dirty
//   outputs of the LED bank.
//   master modport: drives csn/clk/mosi/write_en and button events,
//                   observes miso, led, dirty, read_needed.
//   slave modport : the LED bank side (mirror of master).
interface spi_led_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  logic                    spi_csn;
  logic                    spi_clk;
  logic                    spi_mosi;
  logic                    spi_miso;
  logic                    spi_write_en;
  logic [NUM_CH-1:0]       increment;
  logic [NUM_CH-1:0]       decrement;
  logic [NUM_CH-1:0]       left;
  logic [NUM_CH-1:0]       right;
  logic                    read_needed;
  logic [NUM_CH-1:0]       dirty;
  logic [NUM_CH*WIDTH-1:0] led;

  modport master (
    output spi_csn, spi_clk, spi_mosi, spi_write_en,
    output increment, decrement, left, right,
    input  spi_miso, read_needed, dirty, led
  );

  modport slave (
    input  spi_csn, spi_clk, spi_mosi, spi_write_en,
    input  increment, decrement, left, right,
    output spi_miso, read_needed, dirty, led
  );
endinterface

// File: rtl/spi_led_bank_channel.sv
// spi_led_bank_channel
//   One LED channel: value register, a single-entry pending-op slot used
//   while chip select is active, and the changed-since-last-read flag.
//   clk, rst        : clock, async active-high reset
//   csnActive_i     : synchronised chip select is low (frame in progress)
//   wrEn_i/wrData_i : SPI write commit for this channel
//   rdClr_i         : SPI read of this channel finished its last bit
//   dropPending_i   : channel was written in the frame that just ended
//   inc_i..right_i  : one-cycle button event pulses
//   led_o, dirty_o  : channel value and dirty flag
module spi_led_bank_channel
  import spi_led_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csnActive_i,
  input  logic             wrEn_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             rdClr_i,
  input  logic             dropPending_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             left_i,
  input  logic             right_i,
  output logic [WIDTH-1:0] led_o,
  output logic             dirty_o
);

  logic [WIDTH-1:0] value_q, value_d;
  op_t              pending_q, pending_d;
  logic             dirty_q, dirty_d;
  op_t              newOp;
  logic             setDirty;

  function automatic logic [WIDTH-1:0] applyOp(input logic [WIDTH-1:0] v,
                                               input op_code_e code);
    logic [WIDTH-1:0] r;
    case (code)
      OP_INC:  r = (SATURATE != 0 && v == '1) ? v : v + WIDTH'(1);
      OP_DEC:  r = (SATURATE != 0 && v == '0) ? v : v - WIDTH'(1);
      OP_SHL:  r = v << 1;
      default: r = v >> 1;
    endcase
    return r;
  endfunction

  // Decide this cycle's update. An SPI commit always wins and swallows any
  // coincident button event. Outside a frame a pending op is flushed first
  // (or discarded when the frame wrote this channel); a new event arriving
  // in the flush cycle takes the freed slot and is applied on the next
  // cycle. Inside a frame only the first event is kept. A dirty set beats a
  // same-cycle read clear.
  always_comb begin
    newOp     = encodeOp(inc_i, dec_i, left_i, right_i);
    value_d   = value_q;
    pending_d = pending_q;
    dirty_d   = dirty_q;
    setDirty  = 1'b0;
    if (wrEn_i) begin
      value_d  = wrData_i;
      setDirty = 1'b1;
    end else if (!csnActive_i && pending_q.valid) begin
      if (!dropPending_i) begin
        value_d  = applyOp(value_q, pending_q.code);
        setDirty = 1'b1;
      end
      pending_d = newOp;
    end else if (!csnActive_i && newOp.valid) begin
      value_d  = applyOp(value_q, newOp.code);
      setDirty = 1'b1;
    end else if (csnActive_i && newOp.valid && !pending_q.valid) begin
      pending_d = newOp;
    end
    if (setDirty) begin
      dirty_d = 1'b1;
    end else if (rdClr_i) begin
      dirty_d = 1'b0;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q   <= '0;
      pending_q <= OP_NONE;
      dirty_q   <= 1'b0;
    end else begin
      value_q   <= value_d;
      pending_q <= pending_d;
      dirty_q   <= dirty_d;
    end
  end

  assign led_o   = value_q;
  assign dirty_o = dirty_q;

endmodule

// File: rtl/spi_led_bank.sv
// spi_led_bank
//   SPI mode-0 slave exposing NUM_CH WIDTH-bit LED registers plus a status
//   word (dirty flags at address NUM_CH). Frame: command byte {rw, addr}
//   followed by WIDTH-bit words with address auto-increment.
//   clk   : system clock (spi_clk must be at most clk/8)
//   reset : asynchronous active-high reset, released synchronously
//   bus   : spi_led_bank_if slave modport (SPI pins, button events,
//           led/dirty/read_needed outputs)
module spi_led_bank
  import spi_led_bank_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input logic           clk,
  input logic           reset,
  spi_led_bank_if.slave bus
);

  logic [1:0]            rstSync_q;
  logic                  rst;
  logic [2:0]            csnSync_q;
  logic [2:0]            sclkSync_q;
  logic [1:0]            mosiSync_q;
  logic                  csnS, mosiS, csnFall, csnRise, sclkRise, sclkFall, csnActive;

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [6:0]            cmdShift_q, cmdShift_d;
  logic [WIDTH-1:0]      rxShift_q, rxShift_d;
  logic [WIDTH-1:0]      txShift_q, txShift_d;
  logic [CMD_ADDR_W-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic                  loadReq_q, loadReq_d;
  logic                  skipFall_q, skipFall_d;
  logic                  wordDone;
  logic [NUM_CH-1:0]     wroteInFrame_q;

  logic [NUM_CH-1:0]       wrEnVec, rdClrVec, dirtyBus;
  logic [NUM_CH*WIDTH-1:0] ledBus;
  logic [WIDTH-1:0]        readWord;

  // Reset asserts immediately but releases only on a clock edge so no
  // flop leaves reset in the middle of a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rstSync_q <= 2'b11;
    else       rstSync_q <= {rstSync_q[0], 1'b0};
  end
  assign rst = rstSync_q[1];

  // Two-flop synchronisers; the third csn/sclk stage holds the previous
  // synchronised value for edge detection. csn idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csnSync_q  <= 3'b111;
      sclkSync_q <= 3'b000;
      mosiSync_q <= 2'b00;
    end else begin
      csnSync_q  <= {csnSync_q[1:0], bus.spi_csn};
      sclkSync_q <= {sclkSync_q[1:0], bus.spi_clk};
      mosiSync_q <= {mosiSync_q[0], bus.spi_mosi};
    end
  end

  assign csnS      = csnSync_q[1];
  assign mosiS     = mosiSync_q[1];
  assign csnFall   = !csnSync_q[1] && csnSync_q[2];
  assign csnRise   = csnSync_q[1] && !csnSync_q[2];
  assign sclkRise  = sclkSync_q[1] && !sclkSync_q[2];
  assign sclkFall  = !sclkSync_q[1] && sclkSync_q[2];
  assign csnActive = !csnS;

  // SPI framing FSM. Bits are taken on synced sclk rises; MISO shifts on
  // falls. Right after a word boundary the fresh snapshot is loaded, and the
  // fall that follows the boundary rise must not shift it, so skipFall
  // eats exactly that one fall. The snapshot load is applied last so it
  // wins over anything else touching the transmit register.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    cmdShift_d = cmdShift_q;
    rxShift_d  = rxShift_q;
    txShift_d  = txShift_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    loadReq_d  = 1'b0;
    skipFall_d = skipFall_q;
    wordDone   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (csnFall) begin
          state_d    = ST_CMD;
          bitCnt_d   = '0;
          txShift_d  = '0;
          skipFall_d = 1'b0;
        end
      end
      ST_CMD: begin
        if (csnRise) begin
          state_d = ST_IDLE;
        end else if (sclkRise) begin
          cmdShift_d = {cmdShift_q[5:0], mosiS};
          bitCnt_d   = bitCnt_q + CNT_W'(1);
          if (bitCnt_q == CNT_W'(7)) begin
            rw_d      = cmdShift_q[CMD_RW_BIT-1];
            addr_d    = {cmdShift_q[5:0], mosiS};
            bitCnt_d  = '0;
            state_d   = ST_DATA;
            loadReq_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (csnRise) begin
          state_d = ST_IDLE;
        end else if (sclkRise) begin
          rxShift_d = (rxShift_q << 1) | WIDTH'(mosiS);
          bitCnt_d  = bitCnt_q + CNT_W'(1);
          if (bitCnt_q == CNT_W'(WIDTH - 1)) begin
            wordDone  = 1'b1;
            bitCnt_d  = '0;
            addr_d    = addr_q + CMD_ADDR_W'(1);
            loadReq_d = 1'b1;
          end
        end else if (sclkFall) begin
          if (skipFall_q) skipFall_d = 1'b0;
          else            txShift_d  = txShift_q << 1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (loadReq_q) begin
      txShift_d  = readWord;
      skipFall_d = 1'b1;
    end
  end

  // SPI FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      cmdShift_q <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      loadReq_q  <= 1'b0;
      skipFall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      cmdShift_q <= cmdShift_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      loadReq_q  <= loadReq_d;
      skipFall_q <= skipFall_d;
    end
  end

  // Word-boundary decode: a completed write word commits only when the
  // global gate is open and the address names a real channel; a completed
  // read word clears that channel's dirty flag. Status and out-of-range
  // addresses decode to nothing.
  always_comb begin
    wrEnVec  = '0;
    rdClrVec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wrEnVec[c]  = wordDone && !rw_q && bus.spi_write_en &&
                    (addr_q == CMD_ADDR_W'(c));
      rdClrVec[c] = wordDone && rw_q && (addr_q == CMD_ADDR_W'(c));
    end
  end

  // Remember which channels the current frame wrote so their queued button
  // op is discarded at frame end; forgotten once that flush cycle passes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          wroteInFrame_q <= '0;
    else if (csnRise) wroteInFrame_q <= '0;
    else              wroteInFrame_q <= wroteInFrame_q | wrEnVec;
  end

  // Read mux: channel value, dirty flags at the status address, zero above.
  always_comb begin
    readWord = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr_q == CMD_ADDR_W'(c)) readWord = ledBus[c*WIDTH +: WIDTH];
    end
    if (addr_q == CMD_ADDR_W'(NUM_CH)) readWord[NUM_CH-1:0] = dirtyBus;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    spi_led_bank_channel #(
      .WIDTH   (WIDTH),
      .SATURATE(SATURATE)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .csnActive_i  (csnActive),
      .wrEn_i       (wrEnVec[c]),
      .wrData_i     (rxShift_d),
      .rdClr_i      (rdClrVec[c]),
      .dropPending_i(wroteInFrame_q[c]),
      .inc_i        (bus.increment[c]),
      .dec_i        (bus.decrement[c]),
      .left_i       (bus.left[c]),
      .right_i      (bus.right[c]),
      .led_o        (ledBus[c*WIDTH +: WIDTH]),
      .dirty_o      (dirtyBus[c])
    );
  end

  assign bus.led         = ledBus;
  assign bus.dirty       = dirtyBus;
  assign bus.read_needed = |dirtyBus;
  assign bus.spi_miso    = (state_q == ST_DATA) && txShift_q[WIDTH-1];

endmodule

// File: tb/tb_spi_led_bank.sv
// tb_spi_led_bank
//   Directed bench for spi_led_bank (NUM_CH=4, WIDTH=8). Two instances share
//   all stimulus: busA/dutA wraps on overflow, busB/dutB saturates.
module tb_spi_led_bank;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int K_INC = 0, K_DEC = 1, K_LEFT = 2, K_RIGHT = 3;

  logic clk = 1'b0;
  logic reset;

  spi_led_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) busA ();
  spi_led_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) busB ();

  spi_led_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(0)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave));
  spi_led_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1)) dutB (
    .clk(clk), .reset(reset), .bus(busB.slave));

  assign busB.spi_csn      = busA.spi_csn;
  assign busB.spi_clk      = busA.spi_clk;
  assign busB.spi_mosi     = busA.spi_mosi;
  assign busB.spi_write_en = busA.spi_write_en;
  assign busB.increment    = busA.increment;
  assign busB.decrement    = busA.decrement;
  assign busB.left         = busA.left;
  assign busB.right        = busA.right;

  always #5 clk = ~clk;

  logic [31:0] expQ[$];
  string       tagQ[$];
  int          testsRun    = 0;
  int          testsFailed = 0;

  // Scoreboard push: the expected value is recorded when the stimulus that
  // determines it is issued.
  task automatic pushExpected(input string tag, input logic [31:0] v);
    expQ.push_back(v);
    tagQ.push_back(tag);
  endtask

  // Scoreboard pop and compare against what the DUT produced.
  task automatic checkOutput(input logic [31:0] observed);
    logic [31:0] expv;
    string       tag;
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $error("[TB] FAIL scoreboard_empty observed=0x%0h expected=none", observed);
    end else begin
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      assert (observed === expv) else begin
        testsFailed++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expv);
      end
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle button event pulse on a channel.
  task automatic applyStimulus(input int kind, input int ch);
    @(negedge clk);
    case (kind)
      K_INC:   busA.increment[ch] = 1'b1;
      K_DEC:   busA.decrement[ch] = 1'b1;
      K_LEFT:  busA.left[ch]      = 1'b1;
      default: busA.right[ch]     = 1'b1;
    endcase
    @(negedge clk);
    busA.increment = '0;
    busA.decrement = '0;
    busA.left      = '0;
    busA.right     = '0;
  endtask

  task automatic spiStart();
    @(negedge clk);
    busA.spi_csn = 1'b0;
    waitCycles(8);
  endtask

  task automatic spiEnd();
    waitCycles(8);
    busA.spi_csn = 1'b1;
    waitCycles(10);
  endtask

  // Shift nbits MSB first; MISO is sampled just before each rising edge,
  // which is when a mode-0 master captures it.
  task automatic spiWord(input logic [31:0] txw, input int nbits,
                         output logic [31:0] rxw);
    rxw = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      busA.spi_mosi = txw[i];
      waitCycles(8);
      rxw = {rxw[30:0], busA.spi_miso};
      busA.spi_clk = 1'b1;
      waitCycles(8);
      busA.spi_clk = 1'b0;
    end
  endtask

  // Bound the whole run in case the bench ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [31:0] rx;
    reset             = 1'b1;
    busA.spi_csn      = 1'b1;
    busA.spi_clk      = 1'b0;
    busA.spi_mosi     = 1'b0;
    busA.spi_write_en = 1'b0;
    busA.increment    = '0;
    busA.decrement    = '0;
    busA.left         = '0;
    busA.right        = '0;
    waitCycles(5);
    reset = 1'b0;
    waitCycles(6);

    pushExpected("reset_led", 32'h0);
    checkOutput(32'(busA.led));
    pushExpected("reset_dirty", 32'h0);
    checkOutput(32'(busA.dirty));
    pushExpected("reset_read_needed", 32'h0);
    checkOutput(32'(busA.read_needed));
    pushExpected("reset_miso", 32'h0);
    checkOutput(32'(busA.spi_miso));

    busA.spi_write_en = 1'b1;
    pushExpected("burst_write_cmd_miso", 32'h0);
    spiStart();
    spiWord(32'h01, 8, rx);
    checkOutput(rx);
    spiWord(32'hA5, 8, rx);
    spiWord(32'h3C, 8, rx);
    spiEnd();
    pushExpected("burst_write_led", 32'h003CA500);
    checkOutput(32'(busA.led));
    pushExpected("burst_write_dirty", 32'h6);
    checkOutput(32'(busA.dirty));
    pushExpected("burst_write_read_needed", 32'h1);
    checkOutput(32'(busA.read_needed));

    busA.spi_write_en = 1'b0;
    spiStart();
    spiWord(32'h01, 8, rx);
    spiWord(32'h11, 8, rx);
    spiWord(32'h22, 8, rx);
    spiEnd();
    pushExpected("gated_write_led", 32'h003CA500);
    checkOutput(32'(busA.led));

    pushExpected("read_ch1", 32'hA5);
    pushExpected("read_ch2", 32'h3C);
    spiStart();
    spiWord(32'h81, 8, rx);
    spiWord(32'h00, 8, rx);
    checkOutput(rx);
    spiWord(32'h00, 8, rx);
    checkOutput(rx);
    spiEnd();
    pushExpected("read_clears_dirty", 32'h0);
    checkOutput(32'(busA.dirty));
    pushExpected("read_clears_read_needed", 32'h0);
    checkOutput(32'(busA.read_needed));

    busA.spi_write_en = 1'b1;
    spiStart();
    spiWord(32'h00, 8, rx);
    spiWord(32'hFF, 8, rx);
    spiEnd();
    pushExpected("read_ch0", 32'hFF);
    spiStart();
    spiWord(32'h80, 8, rx);
    spiWord(32'h00, 8, rx);
    checkOutput(rx);
    spiEnd();
    pushExpected("inc_wrap_ch0", 32'h00);
    pushExpected("inc_saturate_ch0", 32'hFF);
    pushExpected("inc_sets_dirty", 32'h1);
    pushExpected("inc_read_needed", 32'h1);
    applyStimulus(K_INC, 0);
    waitCycles(4);
    checkOutput(32'(busA.led[7:0]));
    checkOutput(32'(busB.led[7:0]));
    checkOutput(32'(busA.dirty));
    checkOutput(32'(busA.read_needed));

    spiStart();
    applyStimulus(K_LEFT, 2);
    waitCycles(2);
    applyStimulus(K_INC, 2);
    waitCycles(4);
    pushExpected("pending_held_in_frame", 32'h3C);
    checkOutput(32'(busA.led[23:16]));
    spiEnd();
    pushExpected("pending_applied_once", 32'h78);
    checkOutput(32'(busA.led[23:16]));
    pushExpected("pending_sets_dirty", 32'h5);
    checkOutput(32'(busA.dirty));

    spiStart();
    spiWord(32'h03, 8, rx);
    applyStimulus(K_DEC, 3);
    spiWord(32'h10, 8, rx);
    spiEnd();
    pushExpected("write_drops_pending_ch3", 32'h10);
    checkOutput(32'(busA.led[31:24]));

    spiStart();
    spiWord(32'h04, 8, rx);
    spiWord(32'hFF, 8, rx);
    spiEnd();
    pushExpected("status_write_ignored", 32'h1078A500);
    checkOutput(32'(busA.led));

    pushExpected("read_status", 32'h0D);
    spiStart();
    spiWord(32'h84, 8, rx);
    spiWord(32'h00, 8, rx);
    checkOutput(rx);
    spiEnd();
    pushExpected("read_out_of_range", 32'h00);
    spiStart();
    spiWord(32'h85, 8, rx);
    spiWord(32'h00, 8, rx);
    checkOutput(rx);
    spiEnd();
    pushExpected("status_read_keeps_dirty", 32'hD);
    checkOutput(32'(busA.dirty));

    spiStart();
    spiWord(32'h01, 8, rx);
    spiWord(32'h0F, 4, rx);
    @(negedge clk);
    reset = 1'b1;
    #1;
    pushExpected("midframe_reset_led", 32'h0);
    checkOutput(32'(busA.led));
    pushExpected("midframe_reset_dirty", 32'h0);
    checkOutput(32'(busA.dirty));
    pushExpected("midframe_reset_read_needed", 32'h0);
    checkOutput(32'(busA.read_needed));
    pushExpected("midframe_reset_miso", 32'h0);
    checkOutput(32'(busA.spi_miso));
    busA.spi_csn  = 1'b1;
    busA.spi_clk  = 1'b0;
    busA.spi_mosi = 1'b0;
    waitCycles(4);
    reset = 1'b0;
    waitCycles(20);
    pushExpected("after_reset_led", 32'h0);
    checkOutput(32'(busA.led));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
